oam_dma_arbiter: RTL and testbench
==================================

// Module: oam_dma_arbiter
// PURPOSE
//  Shares the sm83 core's single memory bus between CPU and OAM DMA; owns the FF46 register.
//  CPU write to FF46 starts a copy of DMA_LEN bytes from {src,8'h00} into OAM on a dedicated write port.
//  FF00-FFFF (IO/HRAM) goes to a separate hi port that DMA never blocks.
//  One clk = one M-cycle; memories read synchronously (data valid the cycle after the address).
// PARAMETERS
//  DMA_LEN      160  bytes per transfer (1..256)
//  START_DELAY  1    idle cycles between FF46 write and first DMA read (>=0)
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  cpu_req    in   1   CPU bus access this cycle
//  cpu_write  in   1   1 = write, 0 = read (qualified by cpu_req)
//  cpu_addr   in   16  CPU address
//  cpu_wdata  in   8   CPU write data
//  cpu_rdata  out  8   read data, valid the cycle after a cpu_req read
//  mem_req    out  1   main bus (0000-FEFF) access
//  mem_write  out  1   main bus write strobe
//  mem_addr   out  16  main bus address
//  mem_wdata  out  8   main bus write data
//  mem_rdata  in   8   main bus read data (1-cycle latency)
//  hi_req     out  1   hi bus (FF00-FFFF) access, FF46 excluded
//  hi_write   out  1   hi bus write strobe
//  hi_addr    out  8   cpu_addr[7:0]
//  hi_wdata   out  8   CPU write data
//  hi_rdata   in   8   hi bus read data (1-cycle latency)
//  oam_we     out  1   OAM write strobe
//  oam_addr   out  8   OAM byte index 0..DMA_LEN-1
//  oam_wdata  out  8   OAM write data
//  dma_active out  1   high in DELAY, XFER, DRAIN
// BEHAVIOUR
//  Reset: state IDLE, src=8'hFF, idx=0, every output 0 (cpu_rdata=8'h00).
//  FSM: IDLE -> (FF46 write) DELAY. DELAY counts START_DELAY cycles, then XFER (immediately if 0).
//   XFER issues one read per granted cycle at {src_eff,idx}, then idx++; idx==DMA_LEN-1 read -> DRAIN.
//   DRAIN lasts 1 cycle, then IDLE.
//  src_eff = (src>=8'hE0) ? (src & 8'hDF) : src   (FE->DE, FF->DF echo).
//  OAM write pipeline: oam_we=1 in cycle t iff a DMA read issued in t-1.
//   oam_addr = idx of that read, oam_wdata = mem_rdata. Not cancelled by restart or mode change.
//  FF46 write (any state, DRAIN included): src<=cpu_wdata, idx<=0, go DELAY (restart). Not forwarded to any bus.
//  FF46 read: cpu_rdata next cycle = src.
//  CPU routing by cpu_addr[15:8]:
//   ==FF -> hi port, same cycle, never blocked.
//   else -> mem port, subject to the arbitration mode below.
//  cpu_rdata source (FF46 / hi / mem / blocked) is registered at request time and muxed next cycle.
//  Blocked CPU read returns 8'hFF; blocked CPU write is dropped.
//  Latency, DMA_CPU_BLOCK_EN set, no restart: FF46 write at cycle 0 ->
//   first read at cycle 1+START_DELAY; last oam_we at cycle START_DELAY+DMA_LEN+1;
//   dma_active low from the following cycle.
// CONFIGURATION
//  DMA_CPU_BLOCK_EN defined: DMA owns the mem bus in XFER; CPU 0000-FEFF access blocked.
//   Applies in XFER only; in DELAY/DRAIN the CPU passes through.
//  DMA_CPU_BLOCK_EN undefined: CPU has priority. In an XFER cycle with a CPU mem access,
//   the CPU is granted, no DMA read issues and idx holds; transfer stretches by one cycle per CPU access.
// TESTING
//  1 Reset, FF46 read -> cpu_rdata=8'hFF; all strobes 0.
//  2 Write 8'hC1 to FF46, START_DELAY=1 -> mem reads C100..C19F on cycles 2..161;
//    oam_we 3..162 with oam_addr 0..159 = data; dma_active 1..162.
//  3 BLOCK_EN: CPU read 0150 mid-XFER -> 8'hFF, mem_addr unaffected.
//    CPU write to FF80 -> hi_write=1, hi_addr=8'h80, same cycle.
//  4 No BLOCK_EN: 10 CPU mem accesses in XFER -> CPU granted each time; last oam_we moves 10 cycles later; no byte lost.
//  5 Write 8'hFE to FF46 -> source DE00..DE9F. Restart with 8'h80 at idx=50 ->
//    in-flight byte 49 still written, then 8000.. from idx 0.
//  6 rst asserted mid-XFER -> next cycle IDLE, oam_we=0, src=8'hFF; no further DMA reads.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: shares the CPU main bus with OAM DMA, routes FF00-FFFF to the hi port, owns FF46.
// Define DMA_CPU_BLOCK_EN to give DMA exclusive main-bus ownership during XFER (default: CPU priority).
module oam_dma_arbiter #(
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        mem_req,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        hi_req,
  output logic        hi_write,
  output logic [7:0]  hi_addr,
  output logic [7:0]  hi_wdata,
  input  logic [7:0]  hi_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, DELAY, XFER, DRAIN} state_t;
  typedef enum logic [2:0] {RD_NONE, RD_SRC, RD_HI, RD_MEM, RD_BLOCKED} rd_sel_t;

  localparam logic [7:0]  IDX_LAST    = 8'(DMA_LEN - 1);
  localparam logic [15:0] DELAY_LAST  = (START_DELAY > 0) ? 16'(START_DELAY - 1) : 16'd0;
  localparam state_t      START_STATE = (START_DELAY > 0) ? DELAY : XFER;

  state_t      state, state_next;
  rd_sel_t     rd_sel, rd_sel_next;
  logic [7:0]  src, src_next;
  logic [7:0]  idx, idx_next;
  logic [15:0] delay_cnt, delay_cnt_next;

  logic       cpu_hi, cpu_ff46, ff46_wr, cpu_mem, cpu_blocked, dma_rd;
  logic [7:0] src_eff;

  assign cpu_hi   = (cpu_addr[15:8] == 8'hFF);
  assign cpu_ff46 = cpu_req && (cpu_addr == 16'hFF46);
  assign ff46_wr  = cpu_ff46 && cpu_write;
  assign cpu_mem  = cpu_req && !cpu_hi;
  assign src_eff  = (src >= 8'hE0) ? (src & 8'hDF) : src;

  // A restart cycle issues no DMA read: the FF46 write owns idx that cycle.
`ifdef DMA_CPU_BLOCK_EN
  assign cpu_blocked = (state == XFER) && cpu_mem;
  assign dma_rd      = (state == XFER) && !ff46_wr;
`else
  assign cpu_blocked = 1'b0;
  assign dma_rd      = (state == XFER) && !cpu_mem && !ff46_wr;
`endif

  always_comb begin
    state_next     = state;
    src_next       = src;
    idx_next       = idx;
    delay_cnt_next = delay_cnt;
    unique case (state)
      IDLE:  state_next = IDLE;
      DELAY: begin
        if (delay_cnt == DELAY_LAST) state_next = XFER;
        else delay_cnt_next = delay_cnt + 16'd1;
      end
      XFER: begin
        if (dma_rd) begin
          idx_next = idx + 8'd1;
          if (idx == IDX_LAST) state_next = DRAIN;
        end
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (ff46_wr) begin
      src_next       = cpu_wdata;
      idx_next       = 8'd0;
      delay_cnt_next = 16'd0;
      state_next     = START_STATE;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    hi_req    = 1'b0;
    hi_write  = 1'b0;
    hi_addr   = 8'h00;
    hi_wdata  = 8'h00;
    if (dma_rd) begin
      mem_req  = 1'b1;
      mem_addr = {src_eff, idx};
    end else if (cpu_mem && !cpu_blocked) begin
      mem_req   = 1'b1;
      mem_write = cpu_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_write ? cpu_wdata : 8'h00;
    end
    if (cpu_req && cpu_hi && !cpu_ff46) begin
      hi_req   = 1'b1;
      hi_write = cpu_write;
      hi_addr  = cpu_addr[7:0];
      hi_wdata = cpu_write ? cpu_wdata : 8'h00;
    end
  end

  // The read source is captured with the request; data arrives from it one cycle later.
  always_comb begin
    rd_sel_next = RD_NONE;
    if (cpu_req && !cpu_write) begin
      if (cpu_ff46)         rd_sel_next = RD_SRC;
      else if (cpu_hi)      rd_sel_next = RD_HI;
      else if (cpu_blocked) rd_sel_next = RD_BLOCKED;
      else                  rd_sel_next = RD_MEM;
    end
  end

  always_comb begin
    cpu_rdata = 8'h00;
    case (rd_sel)
      RD_SRC:     cpu_rdata = src;
      RD_HI:      cpu_rdata = hi_rdata;
      RD_MEM:     cpu_rdata = mem_rdata;
      RD_BLOCKED: cpu_rdata = 8'hFF;
      default:    cpu_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= 8'hFF;
      idx       <= 8'd0;
      delay_cnt <= 16'd0;
      rd_sel    <= RD_NONE;
      oam_we    <= 1'b0;
      oam_addr  <= 8'd0;
    end else begin
      src       <= src_next;
      idx       <= idx_next;
      delay_cnt <= delay_cnt_next;
      rd_sel    <= rd_sel_next;
      oam_we    <= dma_rd;
      oam_addr  <= idx;
    end
  end

  assign oam_wdata  = oam_we ? mem_rdata : 8'h00;
  assign dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized scoreboard bench for oam_dma_arbiter; honours DMA_CPU_BLOCK_EN when defined.
module tb_oam_dma_arbiter;
  localparam int DMA_LEN = 160;
  localparam int SD      = 1;
`ifdef DMA_CPU_BLOCK_EN
  localparam bit BLOCK = 1'b1;
`else
  localparam bit BLOCK = 1'b0;
`endif

  logic        clk;
  logic        rst, cpu_req, cpu_write;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        mem_req, mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        hi_req, hi_write;
  logic [7:0]  hi_addr, hi_wdata, hi_rdata;
  logic        oam_we, dma_active;
  logic [7:0]  oam_addr, oam_wdata;

  oam_dma_arbiter #(.DMA_LEN(DMA_LEN), .START_DELAY(SD)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hi_req(hi_req),
    .hi_write(hi_write), .hi_addr(hi_addr), .hi_wdata(hi_wdata), .hi_rdata(hi_rdata),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .dma_active(dma_active)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Environment memories answer one cycle after the address, like the real RAMs.
  logic [7:0] mem_arr [65536];
  logic [7:0] hi_arr  [256];
  always @(posedge clk) begin
    if (mem_req && mem_write) mem_arr[mem_addr] = mem_wdata;
    if (mem_req && !mem_write) mem_rdata <= mem_arr[mem_addr];
    if (hi_req && hi_write) hi_arr[hi_addr] = hi_wdata;
    if (hi_req && !hi_write) hi_rdata <= hi_arr[hi_addr];
  end

  typedef struct {
    int cyc; bit chk; bit mem_req; bit mem_write; logic [15:0] mem_addr; logic [7:0] mem_wdata;
    bit hi_req; bit hi_write; logic [7:0] hi_addr; logic [7:0] hi_wdata; bit active;
  } bus_exp_t;
  typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } oam_exp_t;
  typedef struct { int cyc; logic [7:0] data; } rd_exp_t;

  bus_exp_t bus_q[$];
  oam_exp_t oam_q[$];
  rd_exp_t  rd_q[$];

  logic [7:0] ref_mem [65536];
  logic [7:0] ref_hi  [256];
  logic [7:0] m_src;
  bit         m_active;
  int         m_restart_cyc, m_start_cyc, m_reads, m_last_read_cyc;
  int         cyc, last_oam_cyc, vectors, miscompares;

  function automatic logic [7:0] echoPage(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  function automatic bit modelBusy();
    return m_active && (m_reads < DMA_LEN || cyc <= m_last_read_cyc + 1);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: a transfer copies DMA_LEN bytes of the echo-folded page, one byte per
  // cycle the DMA owns the bus, starting SD+1 cycles after the FF46 write.
  task automatic applyStimulus(input bit r, input bit req, input bit wr,
                               input logic [15:0] a, input logic [7:0] d);
    bus_exp_t    e;
    bit          in_xfer, is_hi, is_ff46, is_mem, blocked, dma;
    logic [15:0] ra;
    logic [7:0]  rv;
    rst = r; cpu_req = req; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    in_xfer = m_active && (cyc >= m_start_cyc) && (m_reads < DMA_LEN);
    is_hi   = req && (a[15:8] == 8'hFF);
    is_ff46 = req && (a == 16'hFF46);
    is_mem  = req && !is_hi;
    blocked = BLOCK && in_xfer && is_mem;
    dma     = in_xfer && !(is_ff46 && wr) && (BLOCK || !is_mem);
    e.cyc = cyc; e.chk = !r; e.mem_req = 0; e.mem_write = 0; e.mem_addr = 0; e.mem_wdata = 0;
    e.hi_req = 0; e.hi_write = 0; e.hi_addr = 0; e.hi_wdata = 0;
    e.active = m_active && (cyc > m_restart_cyc) &&
               (m_reads < DMA_LEN || cyc == m_last_read_cyc + 1);
    if (dma) begin
      ra = {echoPage(m_src), 8'(m_reads)};
      e.mem_req = 1; e.mem_addr = ra;
      if (!r) oam_q.push_back('{cyc: cyc + 1, addr: 8'(m_reads), data: ref_mem[ra]});
      m_reads++;
      m_last_read_cyc = cyc;
    end else if (is_mem && !blocked) begin
      e.mem_req = 1; e.mem_write = wr; e.mem_addr = a; e.mem_wdata = d;
      if (wr) ref_mem[a] = d;
    end
    if (is_hi && !is_ff46) begin
      e.hi_req = 1; e.hi_write = wr; e.hi_addr = a[7:0]; e.hi_wdata = d;
      if (wr) ref_hi[a[7:0]] = d;
    end
    if (req && !wr) begin
      if (is_ff46)      rv = m_src;
      else if (is_hi)   rv = ref_hi[a[7:0]];
      else if (blocked) rv = 8'hFF;
      else              rv = ref_mem[a];
      rd_q.push_back('{cyc: cyc + 1, data: rv});
    end
    if (is_ff46 && wr && !r) begin
      m_src = d; m_active = 1; m_restart_cyc = cyc; m_start_cyc = cyc + 1 + SD; m_reads = 0;
    end
    if (r) begin
      m_src = 8'hFF; m_active = 0;
    end
    bus_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 16'h0000, 8'h00);
  endtask

  task automatic runToIdle();
    int g;
    g = 0;
    while (modelBusy() && g < 1000) begin
      idle(1);
      g++;
    end
    checkOutput("drain_budget", int'(modelBusy()), 0);
    idle(2);
  endtask

  task automatic runToReads(input int n);
    int g;
    g = 0;
    while (m_reads < n && g < 1000) begin
      idle(1);
      g++;
    end
    checkOutput("reads_budget", int'(m_reads >= n), 1);
  endtask

  task automatic monitorLoop();
    bus_exp_t e;
    oam_exp_t o;
    rd_exp_t  r;
    forever begin
      @(negedge clk);
      if (bus_q.size() > 0) begin
        e = bus_q.pop_front();
        if (e.chk) begin
          checkOutput("mem_req", mem_req, e.mem_req);
          if (e.mem_req) begin
            checkOutput("mem_write", mem_write, e.mem_write);
            checkOutput("mem_addr", mem_addr, e.mem_addr);
            if (e.mem_write) checkOutput("mem_wdata", mem_wdata, e.mem_wdata);
          end
          checkOutput("hi_req", hi_req, e.hi_req);
          if (e.hi_req) begin
            checkOutput("hi_write", hi_write, e.hi_write);
            checkOutput("hi_addr", hi_addr, e.hi_addr);
            if (e.hi_write) checkOutput("hi_wdata", hi_wdata, e.hi_wdata);
          end
          checkOutput("dma_active", dma_active, e.active);
        end
      end
      if (oam_q.size() > 0 && oam_q[0].cyc == cyc) begin
        o = oam_q.pop_front();
        checkOutput("oam_we", oam_we, 1);
        checkOutput("oam_addr", oam_addr, o.addr);
        checkOutput("oam_wdata", oam_wdata, o.data);
      end else if (!rst) begin
        checkOutput("oam_we_idle", oam_we, 0);
      end
      if (oam_we) last_oam_cyc = cyc;
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        r = rd_q.pop_front();
        checkOutput("cpu_rdata", cpu_rdata, r.data);
      end
    end
  endtask

  logic [7:0] src_list [8];
  int         c0;
  logic [7:0] v;

  initial begin
    src_list = '{8'hC1, 8'hFE, 8'hFF, 8'h80, 8'hD3, 8'hE5, 8'hA0, 8'h9F};
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      hi_arr[i] = v;
      ref_hi[i] = v;
    end
    m_src = 8'hFF; m_active = 0; m_restart_cyc = 0; m_start_cyc = 0; m_reads = 0;
    m_last_read_cyc = -10; cyc = 0; last_oam_cyc = -1; vectors = 0; miscompares = 0;
    fork
      monitorLoop();
    join_none

    // Reset, then FF46 readback of the reset source and quiet strobes.
    applyStimulus(1, 0, 0, 16'h0000, 8'h00);
    applyStimulus(1, 0, 0, 16'h0000, 8'h00);
    idle(2);
    applyStimulus(0, 1, 0, 16'hFF46, 8'h00);
    idle(2);

    // Transfer from C1 with mid-transfer CPU traffic; 10 main-bus reads stretch it without blocking.
    c0 = cyc;
    applyStimulus(0, 1, 1, 16'hFF46, 8'hC1);
    runToReads(40);
    applyStimulus(0, 1, 1, 16'hFF80, 8'h5A);
    applyStimulus(0, 1, 0, 16'hFF80, 8'h00);
    applyStimulus(0, 1, 0, 16'hFF46, 8'h00);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 16'h0150 + 16'(i), 8'h00);
    runToIdle();
    checkOutput("last_oam_cycle", last_oam_cyc, c0 + SD + DMA_LEN + 1 + (BLOCK ? 0 : 10));

    // Echo source FE, restarted to 80 after 50 bytes.
    applyStimulus(0, 1, 1, 16'hFF46, 8'hFE);
    runToReads(50);
    applyStimulus(0, 1, 1, 16'hFF46, 8'h80);
    runToIdle();

    // Reset in the middle of a transfer.
    applyStimulus(0, 1, 1, 16'hFF46, 8'hD3);
    runToReads(30);
    applyStimulus(1, 0, 0, 16'h0000, 8'h00);
    idle(5);
    applyStimulus(0, 1, 0, 16'hFF46, 8'h00);
    idle(2);

    // Random traffic with occasional starts and restarts.
    for (int n = 0; n < 2500; n++) begin
      int p;
      logic [15:0] a;
      bit wr;
      p = $urandom_range(0, 999);
      if ((!modelBusy() && p < 60) || p < 5) begin
        applyStimulus(0, 1, 1, 16'hFF46, src_list[$urandom_range(0, 7)]);
      end else if (p < 450) begin
        wr = 1'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          a = {8'hFF, 8'($urandom)};
          if (a == 16'hFF46) wr = 1'b0;
        end else if (wr) begin
          a = 16'($urandom_range(0, 16'h7FFF));
        end else begin
          a = 16'($urandom_range(0, 16'hFEFF));
        end
        applyStimulus(0, 1, wr, a, 8'($urandom));
      end else begin
        idle(1);
      end
    end
    runToIdle();
    idle(3);
    checkOutput("oam_queue_left", oam_q.size(), 0);
    checkOutput("rdata_queue_left", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
